// File: rtl/mem_pkg.sv
// mem_pkg: shared types and default constants for the main-memory responder.
// Contents: controller state enum, default geometry/latency constants and the
// derived default block-index width.
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        RD_BURST = 3'd2,
        WR_WAIT  = 3'd3,
        WR_DONE  = 3'd4
    } mem_state_t;

    localparam int ADDR_W_DEF      = 10;
    localparam int DATA_W_DEF      = 32;
    localparam int BLOCK_WORDS_DEF = 4;
    localparam int LATENCY_DEF     = 4;
    localparam int IDX_W_DEF       = $clog2(BLOCK_WORDS_DEF);

endpackage

// File: rtl/mem_array.sv
// mem_array: 2**ADDR_W x DATA_W storage, one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
// Ports:
//   clk   - write clock
//   we    - write enable, commits wdata to waddr at the rising edge
//   waddr - write word address
//   wdata - write data
//   raddr - read word address
//   rdata - read data (combinational)
module mem_array #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/main_mem_responder.sv
// main_mem_responder: memory-side responder for the cache's memory port.
// A strobe in IDLE captures the request; after LATENCY wait cycles a read
// streams one block-aligned cache block word per cycle, a write commits a
// single word.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   MStrobe/MRW       - request strobe and direction (1 = read block)
//   MAddr/MDataIn     - request word address and write data
//   MDataOut/MWordIdx - burst word and its index within the block
//   MRdy              - MDataOut valid
//   MDone             - last burst word or write commit
//   MBusy             - request in progress
module main_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
    parameter int LATENCY     = LATENCY_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           MStrobe,
    input  logic                           MRW,
    input  logic [ADDR_W-1:0]              MAddr,
    input  logic [DATA_W-1:0]              MDataIn,
    output logic [DATA_W-1:0]              MDataOut,
    output logic [$clog2(BLOCK_WORDS)-1:0] MWordIdx,
    output logic                           MRdy,
    output logic                           MDone,
    output logic                           MBusy
);

    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam int CNT_W = $clog2(LATENCY + 1);

    localparam logic [IDX_W-1:0]  IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    mem_state_t        state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [IDX_W-1:0]  idx, idx_nx;
    logic [ADDR_W-1:0] cap_addr, cap_addr_nx;
    logic [DATA_W-1:0] cap_data, cap_data_nx;
    logic              mem_we;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    logic              burst_nx;
    logic              rdy_nx, done_nx, busy_nx;
    logic [DATA_W-1:0] dout_nx;
    logic [IDX_W-1:0]  widx_nx;

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (cap_addr),
        .wdata (cap_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Next-state, wait counter, burst index and request capture.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        idx_nx      = idx;
        cap_addr_nx = cap_addr;
        cap_data_nx = cap_data;
        mem_we      = 1'b0;
        case (state)
            IDLE: begin
                if (MStrobe) begin
                    cap_addr_nx = MAddr;
                    cap_data_nx = MDataIn;
                    cnt_nx      = CNT_LOAD;
                    state_nx    = MRW ? RD_WAIT : WR_WAIT;
                end else begin
                    state_nx = IDLE;
                end
            end
            RD_WAIT: begin
                if (cnt == CNT_ZERO) begin
                    state_nx = RD_BURST;
                    idx_nx   = IDX_ZERO;
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            RD_BURST: begin
                if (idx == IDX_LAST) begin
                    state_nx = IDLE;
                end else begin
                    idx_nx = idx + IDX_ONE;
                end
            end
            WR_WAIT: begin
                if (cnt == CNT_ZERO) begin
                    state_nx = WR_DONE;
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            WR_DONE: begin
                // Commit happens at the edge that returns to IDLE.
                mem_we   = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Outputs are registered, so they are derived from the upcoming state;
    // the read address uses the upcoming index so the word lines up with MRdy.
    always_comb begin
        burst_nx = (state_nx == RD_BURST);
        rd_addr  = {cap_addr_nx[ADDR_W-1:IDX_W], idx_nx};
        rdy_nx   = burst_nx;
        busy_nx  = (state_nx != IDLE);
        done_nx  = (burst_nx && (idx_nx == IDX_LAST)) || (state_nx == WR_DONE);
        if (burst_nx) begin
            dout_nx = rd_data;
            widx_nx = idx_nx;
        end else begin
            dout_nx = DATA_ZERO;
            widx_nx = IDX_ZERO;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= CNT_ZERO;
            idx      <= IDX_ZERO;
            cap_addr <= {ADDR_W{1'b0}};
            cap_data <= DATA_ZERO;
            MDataOut <= DATA_ZERO;
            MWordIdx <= IDX_ZERO;
            MRdy     <= 1'b0;
            MDone    <= 1'b0;
            MBusy    <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            idx      <= idx_nx;
            cap_addr <= cap_addr_nx;
            cap_data <= cap_data_nx;
            MDataOut <= dout_nx;
            MWordIdx <= widx_nx;
            MRdy     <= rdy_nx;
            MDone    <= done_nx;
            MBusy    <= busy_nx;
        end
    end

endmodule

// File: tb/tb_main_mem_responder.sv
// Bench for main_mem_responder: a request-level reference model predicts the
// outputs of every cycle from the accept edge and a word array; directed
// scenarios pin exact values, then a randomized phase runs against the model.
module tb_main_mem_responder;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int BW  = 4;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          MStrobe = 1'b0;
    logic          MRW = 1'b0;
    logic [AW-1:0] MAddr = '0;
    logic [DW-1:0] MDataIn = '0;
    logic [DW-1:0] MDataOut;
    logic [1:0]    MWordIdx;
    logic          MRdy, MDone, MBusy;

    logic          s_strobe = 1'b0;
    logic          s_rw = 1'b0;
    logic [3:0]    s_addr = '0;
    logic [DW-1:0] s_din = '0;
    logic [DW-1:0] s_dout;
    logic [0:0]    s_widx;
    logic          s_rdy, s_done, s_busy;

    always #5 clk = ~clk;

    main_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .BLOCK_WORDS(BW), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .MStrobe(MStrobe), .MRW(MRW), .MAddr(MAddr),
        .MDataIn(MDataIn), .MDataOut(MDataOut), .MWordIdx(MWordIdx),
        .MRdy(MRdy), .MDone(MDone), .MBusy(MBusy)
    );

    main_mem_responder #(.ADDR_W(4), .DATA_W(DW), .BLOCK_WORDS(2), .LATENCY(1)) dut_small (
        .clk(clk), .reset(reset), .MStrobe(s_strobe), .MRW(s_rw), .MAddr(s_addr),
        .MDataIn(s_din), .MDataOut(s_dout), .MWordIdx(s_widx),
        .MRdy(s_rdy), .MDone(s_done), .MBusy(s_busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] mm [0:(1<<AW)-1];
    bit            mk [0:(1<<AW)-1];
    bit            m_busy = 1'b0;
    bit            m_rd = 1'b0;
    int            m_e0 = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    int            edge_n = 0;
    bit            e_busy = 1'b0, e_rdy = 1'b0, e_done = 1'b0, e_known = 1'b0;
    int            e_idx = 0;
    logic [DW-1:0] e_data = '0;

    // Request-level model: one request at a time, timed from its accept edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0;
            e_busy = 1'b0;
            e_rdy  = 1'b0;
            e_done = 1'b0;
        end else begin
            int t;
            logic [AW-1:0] a;
            edge_n++;
            if (m_busy) begin
                if (m_rd && edge_n == m_e0 + LAT + BW) begin
                    m_busy = 1'b0;
                end else if (!m_rd && edge_n == m_e0 + LAT + 1) begin
                    mm[m_addr] = m_data;
                    mk[m_addr] = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (MStrobe) begin
                m_busy = 1'b1;
                m_rd   = MRW;
                m_e0   = edge_n;
                m_addr = MAddr;
                m_data = MDataIn;
            end
            e_busy = m_busy;
            e_rdy  = 1'b0;
            e_done = 1'b0;
            if (m_busy) begin
                t = edge_n - m_e0;
                if (m_rd) begin
                    e_rdy  = (t >= LAT);
                    e_idx  = t - LAT;
                    e_done = (t == LAT + BW - 1);
                    if (e_rdy) begin
                        a = AW'((int'(m_addr) / BW) * BW + e_idx);
                        e_known = mk[a];
                        e_data  = mm[a];
                    end
                end else begin
                    e_done = (t == LAT);
                end
            end
        end
    end

    // Per-cycle compare against the model, away from the rising edge.
    always @(negedge clk) begin
        chk("busy", 32'(MBusy), 32'(e_busy));
        chk("rdy", 32'(MRdy), 32'(e_rdy));
        chk("done", 32'(MDone), 32'(e_done));
        if (e_rdy) begin
            chk("widx", 32'(MWordIdx), 32'(e_idx));
            if (e_known) chk("rdata", MDataOut, e_data);
        end else begin
            chk("dout_zero", MDataOut, 32'h0);
        end
    end

    // ---------------- directed helpers ----------------
    logic [DW-1:0] rd_buf [0:BW-1];

    task automatic wait_idle();
        int n = 0;
        forever begin
            @(negedge clk);
            if (!MBusy) break;
            n++;
            if (n > 100) begin
                chk("idle_timeout", 32'd1, 32'd0);
                break;
            end
        end
    endtask

    // Returns 2 ns after the accept edge E0.
    task automatic issue(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        wait_idle();
        @(posedge clk); #2;
        MStrobe = 1'b1; MRW = rw; MAddr = addr; MDataIn = data;
        @(posedge clk); #2;
        MStrobe = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        issue(1'b0, addr, data);
        wait_idle();
    endtask

    task automatic read_block(input logic [AW-1:0] addr);
        int n;
        for (int i = 0; i < BW; i++) rd_buf[i] = '0;
        issue(1'b1, addr, '0);
        for (n = 0; n < 30; n++) begin
            @(negedge clk);
            if (MRdy) rd_buf[MWordIdx] = MDataOut;
            if (MDone) break;
        end
        if (n == 30) chk("read_timeout", 32'd1, 32'd0);
    endtask

    task automatic s_issue(input logic rw, input logic [3:0] addr, input logic [DW-1:0] data);
        @(posedge clk); #2;
        s_strobe = 1'b1; s_rw = rw; s_addr = addr; s_din = data;
        @(posedge clk); #2;
        s_strobe = 1'b0;
    endtask

    initial begin
        // Reset, asserted away from any clock edge.
        #1 reset = 1'b1;
        #1;
        chk("rst_busy", 32'(MBusy), 32'd0);
        chk("rst_rdy", 32'(MRdy), 32'd0);
        chk("rst_done", 32'(MDone), 32'd0);
        chk("rst_dout", MDataOut, 32'd0);
        chk("rst_widx", 32'(MWordIdx), 32'd0);
        chk("rst_s_busy", 32'(s_busy), 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // Block 8..11 filled, then read from mid-block address 10.
        for (int i = 0; i < 4; i++) do_write(AW'(8 + i), 32'hA0 + 32'(i));
        issue(1'b1, 10'd10, '0);
        for (int j = 0; j <= 8; j++) begin
            @(negedge clk);
            chk("rd_rdy_t", 32'(MRdy), 32'(j >= 4 && j <= 7));
            chk("rd_done_t", 32'(MDone), 32'(j == 7));
            chk("rd_busy_t", 32'(MBusy), 32'(j <= 7));
            if (j >= 4 && j <= 7) begin
                chk("rd_data_t", MDataOut, 32'hA0 + 32'(j - 4));
                chk("rd_idx_t", 32'(MWordIdx), 32'(j - 4));
            end
        end

        // Write then immediate read of the containing block.
        issue(1'b0, 10'd5, 32'hDEADBEEF);
        for (int j = 0; j <= 5; j++) begin
            @(negedge clk);
            chk("wr_done_t", 32'(MDone), 32'(j == 4));
            chk("wr_busy_t", 32'(MBusy), 32'(j <= 4));
        end
        read_block(10'd4);
        chk("raw_word1", rd_buf[1], 32'hDEADBEEF);

        // Strobe held high with a write request through a whole read.
        wait_idle();
        @(posedge clk); #2;
        MStrobe = 1'b1; MRW = 1'b1; MAddr = 10'd4;
        @(posedge clk); #2;
        MRW = 1'b0; MAddr = 10'd5; MDataIn = 32'h12345678;
        for (int i = 0; i < BW; i++) rd_buf[i] = '0;
        for (int j = 0; j <= 9; j++) begin
            @(negedge clk);
            if (MRdy) rd_buf[MWordIdx] = MDataOut;
            if (j == 8) chk("held_idle_gap", 32'(MBusy), 32'd0);
            if (j == 9) chk("held_accept", 32'(MBusy), 32'd1);
        end
        @(posedge clk); #2;
        MStrobe = 1'b0;
        chk("held_read_word1", rd_buf[1], 32'hDEADBEEF);
        wait_idle();
        read_block(10'd4);
        chk("held_write_applied", rd_buf[1], 32'h12345678);

        // Reset in the middle of a write drops it.
        do_write(10'd3, 32'h11);
        issue(1'b0, 10'd3, 32'h22);
        @(posedge clk);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("midwr_rst_busy", 32'(MBusy), 32'd0);
        chk("midwr_rst_done", 32'(MDone), 32'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        read_block(10'd0);
        chk("midwr_dropped", rd_buf[3], 32'h11);

        // Minimal geometry: LATENCY=1, BLOCK_WORDS=2.
        s_issue(1'b0, 4'd2, 32'h55);
        repeat (4) @(negedge clk);
        s_issue(1'b0, 4'd3, 32'h66);
        repeat (4) @(negedge clk);
        s_issue(1'b1, 4'd3, '0);
        for (int j = 0; j <= 3; j++) begin
            @(negedge clk);
            chk("s_rdy_t", 32'(s_rdy), 32'(j == 1 || j == 2));
            chk("s_done_t", 32'(s_done), 32'(j == 2));
            chk("s_busy_t", 32'(s_busy), 32'(j <= 2));
            if (j == 1) begin
                chk("s_data0", s_dout, 32'h55);
                chk("s_idx0", 32'(s_widx), 32'd0);
            end
            if (j == 2) begin
                chk("s_data1", s_dout, 32'h66);
                chk("s_idx1", 32'(s_widx), 32'd1);
            end
        end

        // Randomized traffic on a small address window, with rare resets.
        wait_idle();
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #2;
            MStrobe = ($urandom_range(0, 2) == 0);
            MRW     = 1'($urandom_range(0, 1));
            MAddr   = AW'($urandom_range(0, 31));
            MDataIn = $urandom;
            reset   = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk); #2;
        MStrobe = 1'b0;
        reset   = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
